// File: rtl/rx_bit_sync.sv
// rx_bit_sync: recovers bit timing from the demodulated stream, hunts the sync word, deframes characters.
// Build macro RXSYNC_NUDGE_EN replaces the hard phase snap on din edges with a +1/-1 cycle DPLL nudge.
module rx_bit_sync #(
    parameter int unsigned         BIT_DIV         = 32,
    parameter int unsigned         CHAR_BITS       = 14,
    parameter int unsigned         SYNC_LEN        = 7,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD       = 7'b1110010,
    parameter int unsigned         CHARS_PER_FRAME = 8,
    parameter int unsigned         LOSS_BITS       = 20
) (
    input  logic                 clkIn,
    input  logic                 reset,
    input  logic                 din,
    output logic                 rec_bit_clk,
    output logic                 bit_strobe,
    output logic                 bit_data,
    output logic [CHAR_BITS-1:0] char_data,
    output logic                 char_valid,
    output logic                 locked,
    output logic                 lock_lost
);

    localparam int unsigned PH_W  = $clog2(BIT_DIV);
    localparam int unsigned HALF  = BIT_DIV / 2;
    localparam int unsigned BC_W  = $clog2(CHAR_BITS);
    localparam int unsigned CC_W  = $clog2(CHARS_PER_FRAME + 1);
    localparam int unsigned SIL_W = $clog2(LOSS_BITS + 1);

    typedef enum logic {HUNT, COLLECT} state_t;

    state_t                state, state_nxt;
    logic                  din_m, din_s, din_s_d;
    logic                  din_edge, strobe_c, sil_hit_c;
    logic [PH_W-1:0]       ph, ph_inc, ph_nxt;
    logic [SIL_W-1:0]      sil, sil_nxt;
    logic [SYNC_LEN-1:0]   hist, hist_nxt, hist_shift;
    logic [CHAR_BITS-1:0]  shreg, shreg_nxt, char_shift, char_data_nxt;
    logic [BC_W-1:0]       bit_cnt, bit_cnt_nxt;
    logic [CC_W-1:0]       char_cnt, char_cnt_nxt;
    logic                  char_valid_nxt, lock_lost_nxt;

    // Two-flop synchroniser plus one extra stage for edge detection
    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            din_m   <= 1'b0;
            din_s   <= 1'b0;
            din_s_d <= 1'b0;
        end else begin
            din_m   <= din;
            din_s   <= din_m;
            din_s_d <= din_s;
        end
    end

    assign din_edge  = din_s ^ din_s_d;
    assign strobe_c  = (ph == PH_W'(HALF - 1)) && !din_edge;
    assign sil_hit_c = strobe_c && (sil == SIL_W'(LOSS_BITS - 1));
    assign ph_inc    = (ph == PH_W'(BIT_DIV - 1)) ? '0 : ph + PH_W'(1);

    // Phase tracking: the edge cycle counts as phase 0
    always_comb begin
        ph_nxt = ph_inc;
        if (din_edge) begin
`ifdef RXSYNC_NUDGE_EN
            if (ph >= PH_W'(HALF)) begin
                ph_nxt = ph;
            end else if (ph != '0) begin
                ph_nxt = ph + PH_W'(2);
            end
`else
            ph_nxt = PH_W'(1);
`endif
        end
    end

    always_comb begin
        sil_nxt = sil;
        if (din_edge) begin
            sil_nxt = '0;
        end else if (strobe_c && (sil != SIL_W'(LOSS_BITS))) begin
            sil_nxt = sil + SIL_W'(1);
        end
    end

    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Framer: silence abort takes priority over any bit arriving on the same strobe
    always_comb begin
        state_nxt      = state;
        hist_nxt       = hist;
        shreg_nxt      = shreg;
        bit_cnt_nxt    = bit_cnt;
        char_cnt_nxt   = char_cnt;
        char_data_nxt  = char_data;
        char_valid_nxt = 1'b0;
        lock_lost_nxt  = 1'b0;
        hist_shift     = {hist[SYNC_LEN-2:0], din_s};
        char_shift     = {shreg[CHAR_BITS-2:0], din_s};
        case (state)
            HUNT: begin
                if (strobe_c) begin
                    hist_nxt = hist_shift;
                    if (hist_shift == SYNC_WORD) begin
                        state_nxt    = COLLECT;
                        bit_cnt_nxt  = '0;
                        char_cnt_nxt = '0;
                    end
                end
            end
            COLLECT: begin
                if (sil_hit_c) begin
                    state_nxt     = HUNT;
                    hist_nxt      = '0;
                    bit_cnt_nxt   = '0;
                    char_cnt_nxt  = '0;
                    lock_lost_nxt = 1'b1;
                end else if (strobe_c) begin
                    shreg_nxt = char_shift;
                    if (bit_cnt == BC_W'(CHAR_BITS - 1)) begin
                        bit_cnt_nxt    = '0;
                        char_data_nxt  = char_shift;
                        char_valid_nxt = 1'b1;
                        if (char_cnt == CC_W'(CHARS_PER_FRAME - 1)) begin
                            state_nxt    = HUNT;
                            hist_nxt     = '0;
                            char_cnt_nxt = '0;
                        end else begin
                            char_cnt_nxt = char_cnt + CC_W'(1);
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + BC_W'(1);
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            ph          <= '0;
            sil         <= '0;
            hist        <= '0;
            shreg       <= '0;
            bit_cnt     <= '0;
            char_cnt    <= '0;
            rec_bit_clk <= 1'b0;
            bit_strobe  <= 1'b0;
            bit_data    <= 1'b0;
            char_data   <= '0;
            char_valid  <= 1'b0;
            locked      <= 1'b0;
            lock_lost   <= 1'b0;
        end else begin
            ph          <= ph_nxt;
            sil         <= sil_nxt;
            hist        <= hist_nxt;
            shreg       <= shreg_nxt;
            bit_cnt     <= bit_cnt_nxt;
            char_cnt    <= char_cnt_nxt;
            rec_bit_clk <= (ph_nxt < PH_W'(HALF));
            bit_strobe  <= strobe_c;
            if (strobe_c) begin
                bit_data <= din_s;
            end
            char_data   <= char_data_nxt;
            char_valid  <= char_valid_nxt;
            locked      <= (state_nxt == COLLECT);
            lock_lost   <= lock_lost_nxt;
        end
    end

endmodule

// File: tb/tb_rx_bit_sync.sv
// tb_rx_bit_sync: directed bench for rx_bit_sync at default parameters (BIT_DIV=32).
// Serial bits are driven MSB first, changing 1 time unit after a rising clock edge.
module tb_rx_bit_sync;

    logic        clkIn = 1'b0;
    logic        reset;
    logic        din;
    logic        rec_bit_clk, bit_strobe, bit_data, char_valid, locked, lock_lost;
    logic [13:0] char_data;

    rx_bit_sync dut (
        .clkIn       (clkIn),
        .reset       (reset),
        .din         (din),
        .rec_bit_clk (rec_bit_clk),
        .bit_strobe  (bit_strobe),
        .bit_data    (bit_data),
        .char_data   (char_data),
        .char_valid  (char_valid),
        .locked      (locked),
        .lock_lost   (lock_lost)
    );

    always #5 clkIn = ~clkIn;

    int          total = 0;
    int          bad   = 0;
    int          sb_base;
    logic [6:0]  sync_w = 7'b1110010;
    logic [13:0] frm [8];

    // Cycle count since reset release; DUT phase equals cyc mod 32 while din has no edges
    int unsigned cyc;
    always @(posedge clkIn or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    logic [13:0] cq [$];
    int          sb_count, sb_last, sb_prev, sb_at_lock, lock_rises, ll_count;
    logic        locked_q, ll_locked;

    always @(negedge clkIn) begin
        if (reset) begin
            cq.delete();
            sb_count   = 0;
            sb_last    = 0;
            sb_prev    = 0;
            sb_at_lock = 0;
            lock_rises = 0;
            ll_count   = 0;
            locked_q   = 1'b0;
            ll_locked  = 1'b1;
        end else begin
            if (bit_strobe) begin
                sb_count++;
                sb_prev = sb_last;
                sb_last = int'(cyc);
            end
            if (locked && !locked_q) begin
                lock_rises++;
                sb_at_lock = sb_count;
            end
            if (char_valid) cq.push_back(char_data);
            if (lock_lost) begin
                ll_count++;
                ll_locked = locked;
            end
            locked_q = locked;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qget(input int k);
        return (k < cq.size()) ? 32'(cq[k]) : 32'hDEAD;
    endfunction

    task automatic sample();
        @(negedge clkIn);
        #1;
    endtask

    task automatic align();
        @(posedge clkIn);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        din   = 1'b0;
        repeat (3) @(negedge clkIn);
        reset = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int per);
        din = b;
        repeat (per) @(posedge clkIn);
        #1;
    endtask

    task automatic send_word(input logic [13:0] w, input int per);
        for (int i = 13; i >= 0; i--) send_bit(w[i], per);
    endtask

    // First sync bit is a 0->1 edge; it reaches the phase logic 3 clocks later
    task automatic send_sync(input int per);
        din = sync_w[6];
        repeat (3) @(posedge clkIn);
        #1;
        sb_base = sb_count;
        repeat (per - 3) @(posedge clkIn);
        #1;
        for (int i = 5; i >= 0; i--) send_bit(sync_w[i], per);
    endtask

    task automatic send_frame(input int per);
        send_sync(per);
        for (int k = 0; k < 8; k++) send_word(frm[k], per);
    endtask

    task automatic idle(input int n, input int per);
        for (int i = 0; i < n; i++) send_bit(1'b0, per);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_nchars"}, 32'(cq.size()), 32'd8);
        for (int k = 0; k < 8; k++)
            chk($sformatf("%s_char%0d", tag, k), qget(k), 32'(frm[k]));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [13:0] w;
        frm = '{14'h2A5B, 14'h1C3E, 14'h0F0F, 14'h3333, 14'h1555, 14'h2AAA, 14'h3C3C, 14'h0F3C};
        reset = 1'b1;
        din   = 1'b0;
        repeat (3) @(negedge clkIn);
        #1;
        chk("rst_flags", 32'({rec_bit_clk, bit_strobe, bit_data, char_valid, locked, lock_lost}), 32'd0);
        chk("rst_char_data", 32'(char_data), 32'd0);

        // 1: constant din, free-running strobes at cyc 16, 48, 80
        do_reset();
        repeat (100) @(posedge clkIn);
        sample();
        chk("t1_strobe_count", 32'(sb_count), 32'd3);
        chk("t1_last_strobe", 32'(sb_last), 32'd80);
        chk("t1_strobe_period", 32'(sb_last - sb_prev), 32'd32);
        chk("t1_rec_clk_ph4", 32'(rec_bit_clk), 32'd1);
        chk("t1_locked", 32'(locked), 32'd0);
        chk("t1_nchars", 32'(cq.size()), 32'd0);
        repeat (20) @(posedge clkIn);
        sample();
        chk("t1_rec_clk_ph24", 32'(rec_bit_clk), 32'd0);

        // 2: nominal frame at 32 cycles per bit
        do_reset();
        align();
        idle(3, 32);
        send_frame(32);
        idle(3, 32);
        sample();
        chk("t2_lock_after_7_strobes", 32'(sb_at_lock - sb_base), 32'd7);
        chk("t2_lock_rises", 32'(lock_rises), 32'd1);
        chk("t2_locked_end", 32'(locked), 32'd0);
        chk("t2_lock_lost", 32'(ll_count), 32'd0);
        check_frame("t2");

        // 3: transmitter clock off by one cycle per bit in both directions
        do_reset();
        align();
        idle(3, 33);
        send_frame(33);
        idle(3, 33);
        sample();
        check_frame("t3_p33");
        chk("t3_p33_locked_end", 32'(locked), 32'd0);
        do_reset();
        align();
        idle(3, 31);
        send_frame(31);
        idle(3, 31);
        sample();
        check_frame("t3_p31");
        chk("t3_p31_locked_end", 32'(locked), 32'd0);

        // 4: last edge at bit 7 of char 2, so the 20th silent strobe lands on bit 12 of char 3
        do_reset();
        align();
        idle(3, 32);
        send_sync(32);
        send_word(14'h2A5B, 32);
        send_word(14'h207F, 32);
        for (int i = 0; i < 25; i++) send_bit(1'b1, 32);
        sample();
        chk("t4_nchars", 32'(cq.size()), 32'd2);
        chk("t4_char0", qget(0), 32'h2A5B);
        chk("t4_char1", qget(1), 32'h207F);
        chk("t4_lost_pulses", 32'(ll_count), 32'd1);
        chk("t4_locked_at_lost", 32'(ll_locked), 32'd0);
        chk("t4_locked_end", 32'(locked), 32'd0);

        // 5: asynchronous reset partway through char 5, then a clean relock
        do_reset();
        align();
        idle(3, 32);
        send_sync(32);
        for (int k = 0; k < 4; k++) send_word(frm[k], 32);
        w = frm[4];
        for (int i = 13; i >= 9; i--) send_bit(w[i], 32);
        sample();
        chk("t5_nchars_pre", 32'(cq.size()), 32'd4);
        for (int k = 0; k < 4; k++) chk($sformatf("t5_pre_char%0d", k), qget(k), 32'(frm[k]));
        chk("t5_locked_pre", 32'(locked), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_flags", 32'({rec_bit_clk, bit_strobe, bit_data, char_valid, locked, lock_lost}), 32'd0);
        chk("t5_rst_char_data", 32'(char_data), 32'd0);
        din = 1'b0;
        repeat (3) @(negedge clkIn);
        reset = 1'b0;
        align();
        idle(3, 32);
        send_frame(32);
        idle(3, 32);
        sample();
        check_frame("t5_relock");
        chk("t5_lock_lost", 32'(ll_count), 32'd0);
        chk("t5_lock_rises", 32'(lock_rises), 32'd1);

        // 6: edge reaches the phase logic exactly when ph==15 (posedge 48); ph restarts at 1
        do_reset();
        repeat (45) @(posedge clkIn);
        #1;
        din = 1'b1;
        repeat (25) @(posedge clkIn);
        sample();
        chk("t6_strobe_count", 32'(sb_count), 32'd2);
        chk("t6_next_strobe", 32'(sb_last), 32'd63);
        chk("t6_gap", 32'(sb_last - sb_prev), 32'd47);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
